// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - sequences one mac_unit through a K-element signed dot product
//
// Accepts a dot-product command, fetches operand pairs from the A/B operand
// buffers, issues each pair to a single mac_unit and carries the running sum
// across elements. It returns one ACC_WIDTH result per command. A result
// aborted by a mac_unit timeout is flagged with res_err.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_base_a/cmd_base_b          first A/B operand buffer address
//   cmd_len                        element count K (0 legal)
//   cmd_accum                      1: start from last result, 0: start from 0
//   rd_en, rd_addr_a, rd_addr_b    operand buffer read request
//   rd_data_a, rd_data_b           operand buffer data, valid 1 cycle after rd_en
//   mac_a, mac_b, mac_acc_in       mac_unit operands, held from issue until done
//   mac_valid, mac_rst_acc         mac_unit issue pulse / clear-accumulator flag
//   mac_acc_out, mac_done          mac_unit result and completion
//   res_valid/res_ready            result handshake
//   res_data, res_err              result value and timeout-abort flag

`default_nettype none

module mac_dot_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10,
    parameter int TIMEOUT    = 15   // must be >= 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_a,
    input  logic [ADDR_WIDTH-1:0] cmd_base_b,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_accum,

    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,

    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic [ACC_WIDTH-1:0]  mac_acc_in,
    output logic                  mac_valid,
    output logic                  mac_rst_acc,
    input  logic [ACC_WIDTH-1:0]  mac_acc_out,
    input  logic                  mac_done,

    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_FETCH,
        S_RD,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [1:0]            drain_cnt;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  idx;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  last;
    logic                  zero_start;
    logic                  err;
    logic [TMO_W-1:0]      tmo_cnt;

    logic                  last_elem;
    logic                  tmo_hit;

    // idx < len whenever this is evaluated, so idx+1 cannot overflow LEN_WIDTH.
    assign last_elem = (idx + LEN_WIDTH'(1)) == len;

    // tmo_cnt is 0 in the first WAIT cycle after ISSUE, so reaching TIMEOUT-2
    // means this is the last cycle a done may still arrive; OUT then falls
    // exactly TIMEOUT cycles after ISSUE.
    assign tmo_hit = tmo_cnt == TMO_W'(TIMEOUT - 2);

    assign rd_addr_a = base_a + ADDR_WIDTH'(idx);
    assign rd_addr_b = base_b + ADDR_WIDTH'(idx);
    assign res_data  = acc;
    assign res_err   = err;

    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rd_en       = 1'b0;
        mac_valid   = 1'b0;
        mac_rst_acc = 1'b0;
        res_valid   = 1'b0;

        case (state)
            S_DRAIN: begin
                // mac_done is ignored here so a leftover op from before reset
                // cannot be mistaken for a new element.
                if (drain_cnt == 2'd3) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? S_OUT : S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en      = 1'b1;
                state_next = S_RD;
            end
            S_RD: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                mac_valid   = 1'b1;
                mac_rst_acc = zero_start && (idx == '0);
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    state_next = last_elem ? S_OUT : S_FETCH;
                end else if (tmo_hit) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_DRAIN;
            drain_cnt  <= 2'd0;
            base_a     <= '0;
            base_b     <= '0;
            len        <= '0;
            idx        <= '0;
            acc        <= '0;
            last       <= '0;
            zero_start <= 1'b0;
            err        <= 1'b0;
            tmo_cnt    <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            mac_acc_in <= '0;
        end else begin
            state <= state_next;

            case (state)
                S_DRAIN: begin
                    // Wraps back to 0 on the cycle DRAIN is left.
                    drain_cnt <= drain_cnt + 2'd1;
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        base_a     <= cmd_base_a;
                        base_b     <= cmd_base_b;
                        len        <= cmd_len;
                        idx        <= '0;
                        acc        <= cmd_accum ? last : '0;
                        zero_start <= ~cmd_accum;
                        err        <= 1'b0;
                    end
                end
                S_RD: begin
                    // Operand registers double as the mac_unit issue ports, so
                    // they stay stable until the next element's RD.
                    mac_a      <= rd_data_a;
                    mac_b      <= rd_data_b;
                    mac_acc_in <= acc;
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                end
                S_WAIT: begin
                    if (mac_done) begin
                        acc <= mac_acc_out;
                        idx <= idx + LEN_WIDTH'(1);
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        last <= acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
